// File: rtl/tjmono_data_tx_emu.sv
// TJ-Monopix hit-readout emulator: buffers bus-loaded 27-bit hit words and serialises them on
// TX_CLK/TX_DATA under READ/FREEZE control. Optional macro TJMONO_TX_GRAY_EN Gray-codes te/le.
module tjmono_data_tx_emu #(
  parameter int unsigned ABUSWIDTH  = 16,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                 BUS_CLK,
  input  logic                 RST,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  input  logic [7:0]           BUS_DATA_IN,
  output logic [7:0]           BUS_DATA_OUT,
  input  logic                 BUS_WR,
  input  logic                 BUS_RD,
  input  logic                 READ,
  input  logic                 FREEZE,
  output logic                 TX_CLK,
  output logic                 TX_TOKEN,
  output logic                 TX_DATA,
  output logic                 BUSY
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned FillW = DEPTH_LOG2 + 1;
  localparam int unsigned PtrW  = DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StArmed, StWaitFall, StShift} state_e;

  logic             rst;
  logic             conf_en_q;
  logic [7:0]       conf_div_q, div_eff, div_cnt_q;
  logic [7:0]       stage4_q, stage5_q, stage6_q, stage7_q;
  logic [7:0]       lost_q, rd_err_q;
  logic             read_s1_q, read_s2_q, read_s3_q, read_rise;
  logic             freeze_s1_q, freeze_s2_q;
  logic [26:0]      mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FillW-1:0] fill_q, fill_d, vis_q, vis_d;
  logic             push_req, push_ok, pop, full;
  logic [26:0]      push_word, head, pop_word;
  logic             clk_run, tick, fall_tick, tx_clk_q;
  state_e           state_q;
  logic [26:0]      shreg_q;
  logic [4:0]       bitcnt_q;
  logic             tx_data_q, token_q;

  assign rst = RST | (BUS_WR && (BUS_ADD == ABUSWIDTH'(0)));

  assign read_rise = read_s2_q & ~read_s3_q;
  assign full      = (fill_q == FillW'(Depth));
  assign push_req  = BUS_WR && (BUS_ADD == ABUSWIDTH'(7)) && !RST;
  assign push_word = {BUS_DATA_IN[2:0], stage6_q, stage5_q, stage4_q};
  assign pop       = (state_q == StArmed) && conf_en_q && read_rise && (vis_q != '0);
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign push_ok   = push_req && (!full || pop);
  assign head      = mem_q[rd_ptr_q];

`ifdef TJMONO_TX_GRAY_EN
  assign pop_word = {head[26:21], head[20:15] ^ {1'b0, head[20:16]},
                     head[14:9] ^ {1'b0, head[14:10]}, head[8:0]};
`else
  assign pop_word = head;
`endif

  always_comb begin
    fill_d = fill_q;
    if (push_ok && !pop) begin
      fill_d = fill_q + FillW'(1);
    end else if (!push_ok && pop) begin
      fill_d = fill_q - FillW'(1);
    end
    vis_d = freeze_s2_q ? (vis_q - FillW'(pop)) : fill_d;
  end

  // The clock keeps running after CONF_EN drops until the word in flight is out.
  assign clk_run   = conf_en_q || (state_q == StWaitFall) || (state_q == StShift);
  assign div_eff   = (conf_div_q == 8'd0) ? 8'd1 : conf_div_q;
  assign tick      = clk_run && (div_cnt_q >= div_eff - 8'd1);
  assign fall_tick = tick && tx_clk_q;

  always_ff @(posedge BUS_CLK) begin
    if (rst) begin
      conf_en_q   <= 1'b0;
      conf_div_q  <= 8'd1;
      stage4_q    <= '0;
      stage5_q    <= '0;
      stage6_q    <= '0;
      stage7_q    <= '0;
      lost_q      <= '0;
      rd_err_q    <= '0;
      read_s1_q   <= 1'b0;
      read_s2_q   <= 1'b0;
      read_s3_q   <= 1'b0;
      freeze_s1_q <= 1'b0;
      freeze_s2_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      vis_q       <= '0;
      token_q     <= 1'b0;
    end else begin
      read_s1_q   <= READ;
      read_s2_q   <= read_s1_q;
      read_s3_q   <= read_s2_q;
      freeze_s1_q <= FREEZE;
      freeze_s2_q <= freeze_s1_q;
      fill_q      <= fill_d;
      vis_q       <= vis_d;
      token_q     <= conf_en_q && (vis_q != '0);
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push_req && !push_ok && (lost_q != 8'hFF)) lost_q <= lost_q + 8'd1;
      if (read_rise && (state_q != StArmed) && (rd_err_q != 8'hFF)) begin
        rd_err_q <= rd_err_q + 8'd1;
      end
      if (BUS_WR) begin
        case (BUS_ADD)
          ABUSWIDTH'(2): conf_en_q  <= BUS_DATA_IN[0];
          ABUSWIDTH'(4): stage4_q   <= BUS_DATA_IN;
          ABUSWIDTH'(5): stage5_q   <= BUS_DATA_IN;
          ABUSWIDTH'(6): stage6_q   <= BUS_DATA_IN;
          ABUSWIDTH'(7): stage7_q   <= BUS_DATA_IN;
          ABUSWIDTH'(8): conf_div_q <= BUS_DATA_IN;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_word;
  end

  always_ff @(posedge BUS_CLK) begin
    if (rst || !clk_run) begin
      div_cnt_q <= '0;
      tx_clk_q  <= 1'b0;
    end else if (tick) begin
      div_cnt_q <= '0;
      tx_clk_q  <= ~tx_clk_q;
    end else begin
      div_cnt_q <= div_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      tx_data_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (conf_en_q && (vis_q != '0)) state_q <= StArmed;
        end
        StArmed: begin
          if (!conf_en_q) begin
            state_q <= StIdle;
          end else if (pop) begin
            shreg_q  <= pop_word;
            bitcnt_q <= 5'd27;
            state_q  <= StWaitFall;
          end
        end
        StWaitFall: begin
          if (fall_tick) begin
            tx_data_q <= shreg_q[26];
            shreg_q   <= {shreg_q[25:0], 1'b0};
            bitcnt_q  <= bitcnt_q - 5'd1;
            state_q   <= StShift;
          end
        end
        StShift: begin
          if (fall_tick) begin
            if (bitcnt_q != 5'd0) begin
              tx_data_q <= shreg_q[26];
              shreg_q   <= {shreg_q[25:0], 1'b0};
              bitcnt_q  <= bitcnt_q - 5'd1;
            end else begin
              tx_data_q <= 1'b0;
              state_q   <= (conf_en_q && (vis_q != '0)) ? StArmed : StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (rst || !BUS_RD) begin
      BUS_DATA_OUT <= '0;
    end else begin
      case (BUS_ADD)
        ABUSWIDTH'(0):  BUS_DATA_OUT <= 8'd1;
        ABUSWIDTH'(2):  BUS_DATA_OUT <= {7'b0, conf_en_q};
        ABUSWIDTH'(3):  BUS_DATA_OUT <= 8'(fill_q);
        ABUSWIDTH'(4):  BUS_DATA_OUT <= stage4_q;
        ABUSWIDTH'(5):  BUS_DATA_OUT <= stage5_q;
        ABUSWIDTH'(6):  BUS_DATA_OUT <= stage6_q;
        ABUSWIDTH'(7):  BUS_DATA_OUT <= stage7_q;
        ABUSWIDTH'(8):  BUS_DATA_OUT <= conf_div_q;
        ABUSWIDTH'(9):  BUS_DATA_OUT <= lost_q;
        ABUSWIDTH'(10): BUS_DATA_OUT <= rd_err_q;
        ABUSWIDTH'(11): BUS_DATA_OUT <= {6'b0, freeze_s2_q, token_q};
        default:        BUS_DATA_OUT <= '0;
      endcase
    end
  end

  assign TX_CLK   = tx_clk_q;
  assign TX_DATA  = tx_data_q;
  assign TX_TOKEN = token_q;
  assign BUSY     = (state_q != StIdle);

endmodule
